spi_packet_rx: RTL and testbench

SPI-slave packet receiver that sits directly upstream of fib_table on the SPI→FIB path. It deserialises MOSI bytes from the external SPI master and frames each chip-select window as one NDN packet (interest or data). It buffers the whole packet and validates its length. It then replays the packet to the FIB as a one-cycle RX_valid pulse followed by back-to-back bytes on data_SPI_to_FIB.

---
 rtl/ndn_pkg.sv | 23 ++
 rtl/spi_byte_deserializer.sv | 78 +++++++
 rtl/spi_packet_rx.sv | 147 ++++++++++++++
 tb/tb_spi_packet_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ndn_pkg.sv
// Shared NDN packet constants, emit-state encoding and metadata type decode.
package ndn_pkg;

    localparam int unsigned INTEREST_LEN  = 9;
    localparam int unsigned DATA_LEN      = 41;
    localparam int unsigned TYPE_BIT      = 6;
    localparam int unsigned PREFIX_BYTES  = 8;
    localparam int unsigned PAYLOAD_BYTES = 32;
    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned LEN_W         = $clog2(DATA_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        STREAM
    } emit_state_e;

    // Packet length implied by the metadata byte's type bit.
    function automatic logic [LEN_W-1:0] expected_len(input logic [7:0] meta);
        return meta[TYPE_BIT] ? LEN_W'(INTEREST_LEN) : LEN_W'(DATA_LEN);
    endfunction

endpackage

// File: rtl/spi_byte_deserializer.sv
// Synchronises the SPI pins into clk, detects sclk/cs_n edges and assembles MSB-first bytes.
module spi_byte_deserializer
    import ndn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       cs_fall_o,
    output logic       cs_rise_o,
    output logic       partial_o
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   cs_fall_q, cs_fall_d;
    logic                   cs_rise_q, cs_rise_d;
    logic                   sclk_s, mosi_s, cs_s;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_valid_d = 1'b0;
        cs_fall_d    = cs_prev_q & ~cs_s;
        cs_rise_d    = ~cs_prev_q & cs_s;
        if (cs_fall_d) begin
            bit_cnt_d = 3'd0;
        end else if (!cs_s && sclk_s && !sclk_prev_q) begin
            shift_d      = {shift_q[6:0], mosi_s};
            bit_cnt_d    = bit_cnt_q + 3'd1;
            byte_valid_d = (bit_cnt_q == 3'd7);
        end
    end

    // cs_n idles high so the sync chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            cs_sync_q    <= '1;
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b1;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            byte_valid_q <= 1'b0;
            cs_fall_q    <= 1'b0;
            cs_rise_q    <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev_q  <= sclk_s;
            cs_prev_q    <= cs_s;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_valid_q <= byte_valid_d;
            cs_fall_q    <= cs_fall_d;
            cs_rise_q    <= cs_rise_d;
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_o       = shift_q;
    assign cs_fall_o    = cs_fall_q;
    assign cs_rise_o    = cs_rise_q;
    assign partial_o    = (bit_cnt_q != 3'd0);

endmodule

// File: rtl/spi_packet_rx.sv
// Frames each SPI chip-select window into one NDN packet, validates its length and
// replays it to the FIB as an RX_valid pulse followed by back-to-back bytes.
module spi_packet_rx
    import ndn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       RX_valid,
    output logic [7:0] data_SPI_to_FIB,
    output logic       rx_busy,
    output logic       rx_error
);

    logic       byte_valid, cs_fall, cs_rise, partial;
    logic [7:0] rx_byte;

    spi_byte_deserializer u_deser (
        .clk          (clk),
        .rst          (rst),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_cs_n     (spi_cs_n),
        .byte_valid_o (byte_valid),
        .byte_o       (rx_byte),
        .cs_fall_o    (cs_fall),
        .cs_rise_o    (cs_rise),
        .partial_o    (partial)
    );

    logic [7:0]       pkt_buf_q [DATA_LEN];
    logic             wr_en;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0] exp_len_q, exp_len_d;
    logic             overrun_q, overrun_d;
    emit_state_e      state_q, state_d;
    logic [LEN_W-1:0] rd_idx_q, rd_idx_d;
    logic [LEN_W-1:0] emit_len_q, emit_len_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             emit_done, emit_free, req;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        exp_len_d  = exp_len_q;
        overrun_d  = overrun_q;
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        emit_len_d = emit_len_q;
        data_d     = data_q;
        err_d      = 1'b0;
        wr_en      = 1'b0;
        req        = 1'b0;
        emit_done  = (state_q == STREAM) && (rd_idx_q == emit_len_q - LEN_W'(1));
        emit_free  = (state_q == IDLE) || emit_done;

        if (cs_fall) begin
            byte_cnt_d = '0;
            overrun_d  = 1'b0;
        end else if (byte_valid) begin
            if (byte_cnt_q == LEN_W'(DATA_LEN)) begin
                overrun_d = 1'b1;
            end else begin
                wr_en      = 1'b1;
                byte_cnt_d = byte_cnt_q + LEN_W'(1);
                if (byte_cnt_q == '0) exp_len_d = expected_len(rx_byte);
            end
        end

        // Capture end: accept only a whole, correctly sized packet when the emitter is free.
        if (cs_rise) begin
            byte_cnt_d = '0;
            overrun_d  = 1'b0;
            if (byte_cnt_q != '0 && byte_cnt_q == exp_len_q && !partial && !overrun_q
                && emit_free) begin
                req        = 1'b1;
                emit_len_d = byte_cnt_q;
            end else if (byte_cnt_q != '0 || partial) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = PULSE;
                    rd_idx_d = '0;
                end
            end
            PULSE: state_d = STREAM;
            STREAM: begin
                if (emit_done) begin
                    state_d  = req ? PULSE : IDLE;
                    rd_idx_d = '0;
                end else begin
                    rd_idx_d = rd_idx_q + LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        rx_valid_d = (state_d == PULSE);
        busy_d     = (state_d != IDLE);
        if (state_d == STREAM) data_d = pkt_buf_q[rd_idx_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= '0;
            exp_len_q  <= '0;
            overrun_q  <= 1'b0;
            state_q    <= IDLE;
            rd_idx_q   <= '0;
            emit_len_q <= '0;
            rx_valid_q <= 1'b0;
            data_q     <= 8'd0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            exp_len_q  <= exp_len_d;
            overrun_q  <= overrun_d;
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            emit_len_q <= emit_len_d;
            rx_valid_q <= rx_valid_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Packet storage is not reset; stale contents are never emitted.
    always_ff @(posedge clk) begin
        if (wr_en) pkt_buf_q[byte_cnt_q] <= rx_byte;
    end

    assign RX_valid        = rx_valid_q;
    assign data_SPI_to_FIB = data_q;
    assign rx_busy         = busy_q;
    assign rx_error        = err_q;

endmodule

// File: tb/tb_spi_packet_rx.sv
// Scoreboard bench for spi_packet_rx: directed and random SPI packets vs. a length-rule model.
module tb_spi_packet_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       RX_valid;
    logic [7:0] data_SPI_to_FIB;
    logic       rx_busy;
    logic       rx_error;

    spi_packet_rx dut (
        .clk             (clk),
        .rst             (rst),
        .spi_sclk        (spi_sclk),
        .spi_mosi        (spi_mosi),
        .spi_cs_n        (spi_cs_n),
        .RX_valid        (RX_valid),
        .data_SPI_to_FIB (data_SPI_to_FIB),
        .rx_busy         (rx_busy),
        .rx_error        (rx_error)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_bytes_q[$];
    int         exp_len_q[$];
    int         exp_err = 0;
    int         mon_left = 0;
    bit         mon_idle_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: a window is a packet iff it carries whole bytes and exactly the
    // length its metadata type implies; any other non-empty window is an error.
    task automatic model_expect(input logic [7:0] b[$], input int nbits);
        int nbytes;
        int need;
        logic [7:0] meta;
        if (nbits == 0) return;
        nbytes = nbits / 8;
        meta   = b[0];
        need   = meta[6] ? 9 : 41;
        if (nbits % 8 == 0 && nbytes == need) begin
            exp_len_q.push_back(nbytes);
            for (int i = 0; i < nbytes; i++) exp_bytes_q.push_back(b[i]);
        end else begin
            exp_err++;
        end
    endtask

    task automatic spi_send(input logic [7:0] b[$], input int nbits, input int gap);
        logic [7:0] cur;
        tick(1);
        spi_cs_n = 1'b0;
        tick(3);
        for (int i = 0; i < nbits; i++) begin
            cur      = b[i / 8];
            spi_mosi = cur[7 - (i % 8)];
            tick(5);
            spi_sclk = 1'b1;
            tick(5);
            spi_sclk = 1'b0;
        end
        tick(3);
        spi_cs_n = 1'b1;
        tick(gap);
    endtask

    task automatic send_checked(input logic [7:0] b[$], input int nbits, input int gap);
        model_expect(b, nbits);
        spi_send(b, nbits, gap);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a packet or an error.
    always @(negedge clk) begin
        if (rst) begin
            while (mon_left > 0) begin
                void'(exp_bytes_q.pop_front());
                mon_left--;
            end
            mon_idle_chk = 1'b0;
        end else begin
            if (RX_valid) begin
                check("rx_valid_during_stream", mon_left, 0);
                check("rx_valid_expected", exp_len_q.size() > 0, 1);
                if (exp_len_q.size() > 0) mon_left = exp_len_q.pop_front();
                mon_idle_chk = 1'b0;
            end else if (mon_left > 0) begin
                if (exp_bytes_q.size() > 0)
                    check("stream_byte", data_SPI_to_FIB, exp_bytes_q.pop_front());
                check("busy_in_stream", rx_busy, 1);
                mon_left--;
                mon_idle_chk = (mon_left == 0);
            end else if (mon_idle_chk) begin
                check("busy_after_stream", rx_busy, 0);
                mon_idle_chk = 1'b0;
            end
            if (rx_error) begin
                check("rx_error_expected", exp_err > 0, 1);
                if (exp_err > 0) exp_err--;
            end
        end
    end

    logic [7:0] intr[$];
    logic [7:0] dpkt[$];
    logic [7:0] pk[$];
    string      txt;
    int         k;
    int         kind;
    int         len;
    int         nbits;
    logic [7:0] meta;

    initial begin
        intr = '{8'h70, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
        dpkt = '{8'h30, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
        txt  = "this is an example";
        for (int i = 0; i < 32 - txt.len(); i++) dpkt.push_back(8'h00);
        for (int i = 0; i < txt.len(); i++) dpkt.push_back(txt[i]);

        #1 rst = 1'b1;
        tick(3);
        check("reset_rx_valid", RX_valid, 0);
        check("reset_data", data_SPI_to_FIB, 0);
        check("reset_busy", rx_busy, 0);
        check("reset_error", rx_error, 0);
        rst = 1'b0;
        tick(5);

        send_checked(intr, 72, 60);
        check("data_pkt_last_byte", dpkt[40], 8'h65);
        send_checked(dpkt, 328, 80);

        pk = intr[0:4];
        send_checked(pk, 40, 30);
        check("idle_after_short", rx_busy, 0);
        send_checked(intr, 12, 30);
        send_checked(intr, 72, 60);

        // Reset in the middle of a data emission.
        send_checked(dpkt, 328, 0);
        k = 0;
        while (!RX_valid && k < 200) begin
            tick(1);
            k++;
        end
        check("rst_test_rx_valid_seen", k < 200, 1);
        tick(20);
        #1 rst = 1'b1;
        #1;
        check("midrst_rx_valid", RX_valid, 0);
        check("midrst_data", data_SPI_to_FIB, 0);
        check("midrst_busy", rx_busy, 0);
        check("midrst_error", rx_error, 0);
        tick(3);
        rst = 1'b0;
        tick(5);
        send_checked(intr, 72, 60);

        // Back-to-back windows: next cs_n falls one cycle after the previous rise.
        send_checked(dpkt, 328, 0);
        send_checked(intr, 72, 60);

        for (int n = 0; n < 10; n++) begin
            kind = $urandom_range(0, 4);
            meta = 8'($urandom) & 8'hBF;
            if (kind == 0 || $urandom_range(0, 1) == 1) meta = meta | 8'h40;
            case (kind)
                0:       len = 9;
                1:       len = meta[6] ? 9 : 41;
                2:       len = $urandom_range(1, meta[6] ? 8 : 40);
                3:       len = (meta[6] ? 9 : 41) + $urandom_range(1, 3);
                default: len = meta[6] ? 9 : 41;
            endcase
            pk.delete();
            pk.push_back(meta);
            for (int i = 1; i < len + 1; i++) pk.push_back(8'($urandom));
            nbits = len * 8;
            if (kind == 4) nbits = nbits - $urandom_range(1, 7);
            send_checked(pk, nbits, 60);
        end

        tick(100);
        check("pkts_drained", exp_len_q.size(), 0);
        check("errors_drained", exp_err, 0);
        check("stream_drained", mon_left, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
